testeio_mem_port_arbiter: RTL and testbench
===========================================

// Module: testeio_mem_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing one port of the 16K x 32 on-chip dual-port RAM between two Avalon-MM masters
//  (m0, m1), e.g. the CPU data path and the genetic-circuit evaluator engine.
//  Sits between the two masters and the RAM s1/s2 port; the RAM's other port is untouched.
//  Pipelined Avalon protocol: waitrequest stalls a master; readdatavalid returns reads at fixed latency 1.
// PARAMETERS
//  ADDR_W    14  word address width of RAM port
//  DATA_W    32  data width
//  BE_W       4  byteenable width (DATA_W/8)
//  HOLD_MAX   4  max consecutive transfers an owner keeps the port while the other master requests (>=1)
// PORTS
//  clk                  in   1       single clock, same clock as the RAM port
//  reset_n              in   1       asynchronous active-low reset
//  m0_/m1_address       in   ADDR_W  master word address
//  m0_/m1_byteenable    in   BE_W    master byte enables
//  m0_/m1_read          in   1       read request
//  m0_/m1_write         in   1       write request (read & write together = write)
//  m0_/m1_writedata     in   DATA_W  write data
//  m0_/m1_waitrequest   out  1       1 = request not accepted this cycle, hold all inputs
//  m0_/m1_readdata      out  DATA_W  read data, valid only with readdatavalid
//  m0_/m1_readdatavalid out  1       read data strobe, 1 cycle after read acceptance
//  mem_address          out  ADDR_W  to RAM address
//  mem_byteenable       out  BE_W    to RAM byteenable
//  mem_chipselect       out  1       to RAM chipselect
//  mem_write            out  1       to RAM write
//  mem_writedata        out  DATA_W  to RAM writedata
//  mem_readdata         in   DATA_W  from RAM q (address registered in RAM, output unregistered: latency 1)
// BEHAVIOUR
//  - req_i = mi_read | mi_write. At most one transfer issued per cycle; issue is combinational from req_i + state.
//  - Granted master i, cycle N: mem_chipselect=1, mem_* = mi_*, mem_write=mi_write, mi_waitrequest=0.
//    Non-granted requester: waitrequest=1. Non-requesting master: waitrequest=1 (don't care).
//  - Read accepted in cycle N -> mi_readdatavalid=1 in N+1 with mi_readdata=mem_readdata; back-to-back
//    reads each cycle give one readdatavalid per cycle, in order. Writes produce no response.
//  - Owner FSM (registered, updated on each issue):
//    IDLE: none request -> stay. One requests -> grant it, go OWNi, hold_cnt=1.
//          Both -> grant master != last_grant, go OWNi.
//    OWNi: req_i & (!req_j | hold_cnt<HOLD_MAX) -> grant i, hold_cnt++ (saturate at HOLD_MAX).
//          req_j & (!req_i | hold_cnt==HOLD_MAX) -> grant j, go OWNj, hold_cnt=1, last_grant=i.
//          neither -> IDLE, no issue, hold_cnt=0.
//  - hold_cnt only limits ownership when the other master requests; a lone master streams indefinitely.
//  - No starvation: with both requesting continuously, each gets exactly HOLD_MAX consecutive grants.
//  - Reset (async, reset_n=0): state=IDLE, last_grant=1 (m0 wins first tie), hold_cnt=0, readdatavalid=0,
//    run flag=0. While run=0 (reset and first clk edge after release): mem_chipselect=0, mem_write=0,
//    both waitrequest=1. Reset mid-read: pending readdatavalid dropped, never emitted.
//  - Master dropping request while waitrequest=1 is a protocol violation; arbiter takes no special action.
// CONFIGURATION
//  TESTEIO_MEMARB_FIXED_PRI_EN defined: m0 has absolute priority; m1 granted only when req_0=0,
//    HOLD_MAX and last_grant ignored (m0 may starve m1, intended for real-time evaluator on m0).
//  Undefined (default): round-robin with HOLD_MAX hold as above.
// TESTING
//  1. Reset release, no requests -> mem_chipselect=0, both waitrequest=1, readdatavalid=0 for 10 cycles.
//  2. m0 write 0x1234 data 0xDEADBEEF be=0xF, then m1 read 0x1234 -> m1_readdatavalid 1 cycle after accept, readdata=0xDEADBEEF.
//  3. Both stream reads continuously, HOLD_MAX=4 -> grant pattern m0x4,m1x4,m0x4...; readdatavalid per master matches.
//  4. m1 alone issues 20 back-to-back reads -> 20 accepts in 20 cycles, no waitrequest, data in address order.
//  5. Byte write be=0x2 data 0x0000AB00 to word holding 0x11223344 -> read returns 0x1122AB44.
//  6. Assert reset_n low the cycle after a read accept -> no readdatavalid; after release first tie goes to m0.

Source files
------------

// File: rtl/testeio_mem_port_arbiter.sv
// testeio_mem_port_arbiter: round-robin arbiter (HOLD_MAX burst hold) sharing one RAM port between two
// pipelined Avalon-MM masters; TESTEIO_MEMARB_FIXED_PRI_EN gives m0 absolute priority instead.
module testeio_mem_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int BE_W     = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);
    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HMAX = CW'(HOLD_MAX);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          last_q, last_d;
    logic          run_q, rv0_q, rv1_q;
    logic          req0, req1, g0, g1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef TESTEIO_MEMARB_FIXED_PRI_EN
    assign g0 = run_q & req0;
    assign g1 = run_q & req1 & ~req0;
`else
    logic hold_ok;
    assign hold_ok = hold_q < HMAX;
    // m0 wins unless m1 owns and may keep going, or the tie-break favours m1
    assign g0 = run_q & req0 & ((state_q == OWN0) ? (~req1 | hold_ok) :
                                (state_q == OWN1) ? ~(req1 & hold_ok) : (~req1 | last_q));
    assign g1 = run_q & req1 & ~g0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        if (run_q) begin
            if (!(g0 || g1)) begin
                state_d = IDLE;
                hold_d  = '0;
            end else if ((g0 && state_q == OWN0) || (g1 && state_q == OWN1)) begin
                hold_d = (hold_q == HMAX) ? HMAX : hold_q + CW'(1);
            end else begin
                state_d = g0 ? OWN0 : OWN1;
                hold_d  = CW'(1);
                last_d  = (state_q == IDLE) ? last_q : (state_q == OWN1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            last_q  <= 1'b1;
            run_q   <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            run_q   <= 1'b1;
            rv0_q   <= g0 & m0_read & ~m0_write;
            rv1_q   <= g1 & m1_read & ~m1_write;
        end
    end

    assign mem_chipselect   = g0 | g1;
    assign mem_write        = (g0 & m0_write) | (g1 & m1_write);
    assign mem_address      = g1 ? m1_address    : m0_address;
    assign mem_byteenable   = g1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata    = g1 ? m1_writedata  : m0_writedata;
    assign m0_waitrequest   = ~g0;
    assign m1_waitrequest   = ~g1;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rv0_q;
    assign m1_readdatavalid = rv1_q;
endmodule

// File: tb/tb_testeio_mem_port_arbiter.sv
// tb_testeio_mem_port_arbiter: random and directed traffic from two masters against a RAM model,
// checked by a transaction-level arbitration/memory reference model.
module tb_testeio_mem_port_arbiter;
    localparam int HOLD_MAX = 4;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, mem_writedata, mem_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic        mem_chipselect, mem_write;

    always #5 clk = ~clk;

    testeio_mem_port_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    function automatic logic [31:0] init_word(input int a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    // RAM port: registered address, unregistered data out
    logic [31:0] ram [16384];
    logic [13:0] ram_aq;
    assign mem_readdata = ram[ram_aq];
    initial begin
        for (int a = 0; a < 16384; a++) ram[a] = init_word(a);
        ram_aq = '0;
        forever begin
            @(posedge clk);
            ram_aq <= mem_address;
            if (mem_chipselect && mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
        end
    end

    int          vectors = 0, errors = 0;
    logic [31:0] shadow [16384];
    int          owner = -1, streak = 0, last = 1;
    bit          run = 1'b0;
    bit          exp_rdv [2];
    logic [31:0] exp_dat [2];
    bit          acc [2];
    req_t        cur [2];
    req_t        idle_r;
    req_t        q0 [$];
    req_t        q1 [$];
    int          obs_g = -1;
    int          n_acc [2];
    logic [31:0] last_rd [2];
    int          grants [$];
    bit          rec = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Who gets the port this cycle, from ownership history and the request pair
    function automatic int pick(input bit r0, input bit r1);
        if (!run || !(r0 || r1)) return -1;
`ifdef TESTEIO_MEMARB_FIXED_PRI_EN
        return r0 ? 0 : 1;
`else
        if (r0 && r1) begin
            if (owner < 0) return 1 - last;
            return (streak < HOLD_MAX) ? owner : 1 - owner;
        end
        return r0 ? 0 : 1;
`endif
    endfunction

    task automatic drive();
        m0_read = cur[0].rd; m0_write = cur[0].wr; m0_address = cur[0].addr;
        m0_byteenable = cur[0].be; m0_writedata = cur[0].data;
        m1_read = cur[1].rd; m1_write = cur[1].wr; m1_address = cur[1].addr;
        m1_byteenable = cur[1].be; m1_writedata = cur[1].data;
    endtask

    task automatic push(input int m, input bit rd, input bit wr, input int addr, input logic [3:0] be,
                        input logic [31:0] data);
        req_t r;
        r = '{rd: rd, wr: wr, addr: 14'(addr), be: be, data: data};
        if (m == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    function automatic bit busy();
        return q0.size() != 0 || q1.size() != 0 || ((cur[0].rd || cur[0].wr) && !acc[0]) ||
               ((cur[1].rd || cur[1].wr) && !acc[1]);
    endfunction

    task automatic step();
        int          g;
        bit          r0, r1;
        bit          nrdv [2];
        logic [31:0] ndat [2];
        if (!(cur[0].rd || cur[0].wr) || acc[0]) cur[0] = (q0.size() > 0) ? q0.pop_front() : idle_r;
        if (!(cur[1].rd || cur[1].wr) || acc[1]) cur[1] = (q1.size() > 0) ? q1.pop_front() : idle_r;
        acc[0] = 1'b0; acc[1] = 1'b0;
        nrdv[0] = 1'b0; nrdv[1] = 1'b0;
        ndat[0] = '0; ndat[1] = '0;
        drive();
        @(negedge clk);
        r0 = cur[0].rd || cur[0].wr;
        r1 = cur[1].rd || cur[1].wr;
        g = pick(r0, r1);
        chk("m0_wait", m0_waitrequest, g != 0);
        chk("m1_wait", m1_waitrequest, g != 1);
        chk("mem_cs", mem_chipselect, g >= 0);
        chk("m0_rdv", m0_readdatavalid, exp_rdv[0]);
        chk("m1_rdv", m1_readdatavalid, exp_rdv[1]);
        if (exp_rdv[0]) chk("m0_rdata", m0_readdata, exp_dat[0]);
        if (exp_rdv[1]) chk("m1_rdata", m1_readdata, exp_dat[1]);
        obs_g = !m0_waitrequest ? 0 : !m1_waitrequest ? 1 : -1;
        if (!m0_waitrequest && r0) n_acc[0]++;
        if (!m1_waitrequest && r1) n_acc[1]++;
        if (m0_readdatavalid) last_rd[0] = m0_readdata;
        if (m1_readdatavalid) last_rd[1] = m1_readdata;
        if (rec && obs_g >= 0) grants.push_back(obs_g);
        if (g >= 0) begin
            chk("mem_write", mem_write, cur[g].wr);
            chk("mem_addr", mem_address, cur[g].addr);
            if (cur[g].wr) begin
                chk("mem_be", mem_byteenable, cur[g].be);
                chk("mem_wdata", mem_writedata, cur[g].data);
                shadow[cur[g].addr] = merge(shadow[cur[g].addr], cur[g].data, cur[g].be);
            end else begin
                nrdv[g] = 1'b1;
                ndat[g] = shadow[cur[g].addr];
            end
            if (g == owner) streak++;
            else begin
                if (owner >= 0) last = owner;
                owner = g;
                streak = 1;
            end
        end else begin
            chk("mem_write", mem_write, 1'b0);
            if (run) begin owner = -1; streak = 0; end
        end
        @(posedge clk);
        if (reset_n) run = 1'b1;
        exp_rdv = nrdv;
        exp_dat = ndat;
        if (g >= 0) acc[g] = 1'b1;
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        owner = -1; streak = 0; last = 1; run = 1'b0;
        exp_rdv[0] = 1'b0; exp_rdv[1] = 1'b0;
        acc[0] = 1'b0; acc[1] = 1'b0;
        q0.delete(); q1.delete();
        cur[0] = idle_r; cur[1] = idle_r;
        drive();
        repeat (cycles) step();
        reset_n = 1'b1;
    endtask

    task automatic drain(input int limit);
        int c = 0;
        while (c < limit && busy()) begin step(); c++; end
        chk("drain", busy(), 1'b0);
        step();
        step();
    endtask

    initial begin
        idle_r = '{rd: 1'b0, wr: 1'b0, addr: '0, be: '0, data: '0};
        for (int a = 0; a < 16384; a++) shadow[a] = init_word(a);
        last_rd[0] = '0; last_rd[1] = '0;
        n_acc[0] = 0; n_acc[1] = 0;
        exp_dat[0] = '0; exp_dat[1] = '0;
        do_reset(3);
        // idle after reset release
        repeat (10) step();
        // write by m0, then read back by m1
        push(0, 0, 1, 'h1234, 4'hF, 32'hDEADBEEF);
        push(1, 1, 0, 'h1234, 4'hF, 32'h0);
        drain(20);
        chk("t2_rdata", last_rd[1], 32'hDEADBEEF);
        // both masters streaming reads from reset: alternating bursts of HOLD_MAX
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            push(0, 1, 0, $urandom_range(0, 16383), 4'hF, 32'h0);
            push(1, 1, 0, $urandom_range(0, 16383), 4'hF, 32'h0);
        end
        rec = 1'b1;
        drain(200);
        rec = 1'b0;
        chk("t3_grants", grants.size(), 80);
        for (int i = 0; i < 16 && i < grants.size(); i++) chk("t3_pattern", grants[i], (i / HOLD_MAX) % 2);
        // lone m1 streams back-to-back
        n_acc[1] = 0;
        for (int i = 0; i < 20; i++) push(1, 1, 0, 100 + i, 4'hF, 32'h0);
        repeat (20) step();
        chk("t4_accepts", n_acc[1], 20);
        step();
        step();
        // byte-lane write
        push(0, 0, 1, 'h200, 4'hF, 32'h11223344);
        push(0, 0, 1, 'h200, 4'h2, 32'h0000AB00);
        push(0, 1, 0, 'h200, 4'hF, 32'h0);
        drain(20);
        chk("t5_rdata", last_rd[0], 32'h1122AB44);
        // reset right after an m1 read accept drops its response; first tie afterwards goes to m0
        push(0, 1, 0, 'h10, 4'hF, 32'h0);
        push(1, 1, 0, 'h11, 4'hF, 32'h0);
        for (int c = 0; c < 6 && !acc[1]; c++) step();
        chk("t6_accept", acc[1], 1'b1);
        do_reset(2);
        push(0, 1, 0, 'h20, 4'hF, 32'h0);
        push(1, 1, 0, 'h21, 4'hF, 32'h0);
        step();
        step();
        chk("t6_tie", obs_g, 0);
        drain(20);
        // random mixed traffic
        for (int n = 0; n < 1500; n++) begin
            if (q0.size() < 2) begin
                if ($urandom_range(0, 9) < 2) push(0, 0, 0, 0, 4'h0, 32'h0);
                else push(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                          4'($urandom_range(0, 15)), $urandom);
            end
            if (q1.size() < 2) begin
                if ($urandom_range(0, 9) < 3) push(1, 0, 0, 0, 4'h0, 32'h0);
                else push(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                          4'($urandom_range(0, 15)), $urandom);
            end
            step();
        end
        drain(50);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
